gfx_draw_arbiter: RTL

//  Round-robin scheduler sharing the Graphics IP M00_AXI write-master engine among
//  NUM_REQ draw requesters (player, enemies, bullets, background). Grants one

---
 rtl/gfx_draw_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/gfx_draw_arbiter.sv
// Round-robin arbiter sharing one AXI write-master engine among NUM_REQ draw requesters.
// Optional watchdog on the engine response is enabled by defining GFX_ARB_TIMEOUT_EN.
module gfx_draw_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic [NUM_REQ-1:0]        done_o,
  output logic                      err_o,
  output logic [ADDR_W-1:0]         txn_addr_o,
  output logic [DATA_W-1:0]         txn_data_o,
  output logic                      init_txn_o,
  input  logic                      txn_done_i,
  input  logic                      txn_error_i,
  output logic                      busy_o
);
  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_cfg
    $error("gfx_draw_arbiter: unsupported parameter set");
  end

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] pick;
  logic [IDX_W:0]   scan;
  logic             txn_done_q;
  logic             done_rise;

`ifdef GFX_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt;
`endif

  // Walk downward so the lowest offset from rr_ptr is the last (winning) assignment.
  always_comb begin
    pick = rr_ptr;
    scan = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      scan = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (scan >= (IDX_W+1)'(NUM_REQ)) scan = scan - (IDX_W+1)'(NUM_REQ);
      if (req_i[scan[IDX_W-1:0]]) pick = scan[IDX_W-1:0];
    end
  end

  // A done level left high by the previous transaction is not a new completion.
  assign done_rise = txn_done_i & ~txn_done_q;
  assign busy_o    = (state != IDLE);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      grant_o    <= '0;
      done_o     <= '0;
      err_o      <= 1'b0;
      txn_addr_o <= '0;
      txn_data_o <= '0;
      init_txn_o <= 1'b0;
      txn_done_q <= 1'b0;
`ifdef GFX_ARB_TIMEOUT_EN
      wd_cnt     <= '0;
`endif
    end else begin
      txn_done_q <= txn_done_i;
      init_txn_o <= 1'b0;
      done_o     <= '0;
      err_o      <= 1'b0;
      case (state)
        IDLE: if (|req_i) begin
          owner      <= pick;
          grant_o    <= NUM_REQ'(1) << pick;
          txn_addr_o <= req_addr_i[pick*ADDR_W +: ADDR_W];
          txn_data_o <= req_data_i[pick*DATA_W +: DATA_W];
          state      <= LAUNCH;
        end
        LAUNCH: begin
          init_txn_o <= 1'b1;
          state      <= WAIT;
`ifdef GFX_ARB_TIMEOUT_EN
          wd_cnt     <= '0;
`endif
        end
        WAIT: begin
          // done_o/err_o are registered here so they are visible during RESP.
          if (done_rise) begin
            done_o <= grant_o;
            err_o  <= txn_error_i;
            state  <= RESP;
          end
`ifdef GFX_ARB_TIMEOUT_EN
          else if (wd_cnt == 16'(TIMEOUT_CYC - 1)) begin
            done_o <= grant_o;
            err_o  <= 1'b1;
            state  <= RESP;
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
`endif
        end
        RESP: begin
          grant_o <= '0;
          rr_ptr  <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
